// File: rtl/sdu_uart_rx.sv
// sdu_uart_rx
// UART receiver feeding the SDU command decoder. Oversamples the host line,
// validates start and stop bits and presents each byte as a one-cycle pulse.
// Frame format is 8N1, LSB first, idle high.
//
// Optional feature: define SDU_RX_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit (8E1). Without it par_err is tied low.
//
// Parameters:
//   CLK_FREQ    system clock frequency in Hz
//   BAUD        line baud rate
//   OVERSAMPLE  samples per bit (even, >= 4)
//
// Ports:
//   clk        system clock, rising edge
//   rstn       synchronous active-low reset
//   rxd        asynchronous serial line, idle high
//   dout       last correctly received byte
//   dout_vld   one-cycle pulse, dout updated this cycle
//   frame_err  one-cycle pulse, stop bit sampled low
//   par_err    one-cycle pulse, parity mismatch (parity build only)
//   busy       high while a frame is being received
module sdu_uart_rx #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    output logic [7:0] dout,
    output logic       dout_vld,
    output logic       frame_err,
    output logic       par_err,
    output logic       busy
);

    // Clocks per sample tick, never below one.
    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TCW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SCW     = $clog2(OVERSAMPLE);

    localparam logic [TCW-1:0] TC_MAX  = TCW'(DIV - 1);
    localparam logic [SCW-1:0] SC_MID  = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t         state_q, state_d;
    logic           sync1_q;
    logic           rxs_q;
    logic [TCW-1:0] tc_q, tc_d;
    logic [SCW-1:0] sc_q, sc_d;
    logic [2:0]     bc_q, bc_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     dout_q, dout_d;
    logic           dout_vld_q, dout_vld_d;
    logic           frame_err_q, frame_err_d;
    logic           tick;
`ifdef SDU_RX_PARITY_EN
    logic           par_bit_q, par_bit_d;
    logic           par_err_q, par_err_d;
`endif

    assign tick = (tc_q == TC_MAX);

    // Next-state logic. The start bit is confirmed at its middle; from then
    // on every sample lands OVERSAMPLE ticks later, i.e. mid-bit. Because the
    // stop bit is judged mid-bit, IDLE is back in time for a start edge that
    // follows the stop bit with no gap.
    always_comb begin
        state_d     = state_q;
        tc_d        = tick ? '0 : tc_q + 1'b1;
        sc_d        = sc_q;
        bc_d        = bc_q;
        shift_d     = shift_q;
        dout_d      = dout_q;
        dout_vld_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef SDU_RX_PARITY_EN
        par_bit_d   = par_bit_q;
        par_err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    state_d = S_START;
                    sc_d    = '0;
                    // Restart the tick phase so sampling aligns to the edge.
                    tc_d    = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (sc_q == SC_MID) begin
                        sc_d    = '0;
                        bc_d    = '0;
                        state_d = rxs_q ? S_IDLE : S_DATA;
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (sc_q == SC_LAST) begin
                        sc_d          = '0;
                        shift_d[bc_q] = rxs_q;
                        if (bc_q == 3'd7) begin
`ifdef SDU_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bc_d = bc_q + 1'b1;
                        end
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
`ifdef SDU_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    if (sc_q == SC_LAST) begin
                        sc_d      = '0;
                        par_bit_d = rxs_q;
                        state_d   = S_STOP;
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (sc_q == SC_LAST) begin
                        sc_d = '0;
                        // A bad stop bit wins over a parity mismatch.
                        if (!rxs_q) begin
                            frame_err_d = 1'b1;
                            state_d     = S_BREAK;
`ifdef SDU_RX_PARITY_EN
                        end else if ((^shift_q) ^ par_bit_q) begin
                            par_err_d = 1'b1;
                            state_d   = S_IDLE;
`endif
                        end else begin
                            dout_d     = shift_q;
                            dout_vld_d = 1'b1;
                            state_d    = S_IDLE;
                        end
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
            S_BREAK: begin
                // Held-low line: wait for idle so only one error is reported.
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers, including the two-stage synchroniser which resets to
    // the idle (high) line level so reset release never looks like a start.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= S_IDLE;
            tc_q        <= '0;
            sc_q        <= '0;
            bc_q        <= '0;
            shift_q     <= '0;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef SDU_RX_PARITY_EN
            par_bit_q   <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            sync1_q     <= rxd;
            rxs_q       <= sync1_q;
            state_q     <= state_d;
            tc_q        <= tc_d;
            sc_q        <= sc_d;
            bc_q        <= bc_d;
            shift_q     <= shift_d;
            dout_q      <= dout_d;
            dout_vld_q  <= dout_vld_d;
            frame_err_q <= frame_err_d;
`ifdef SDU_RX_PARITY_EN
            par_bit_q   <= par_bit_d;
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign dout      = dout_q;
    assign dout_vld  = dout_vld_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != S_IDLE);
`ifdef SDU_RX_PARITY_EN
    assign par_err   = par_err_q;
`else
    assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sdu_uart_rx.sv
// tb_sdu_uart_rx
// Directed testbench for sdu_uart_rx with CLK_FREQ=1.6 MHz, BAUD=100 kBd,
// giving one sample tick per clock and 16 clocks per bit.
module tb_sdu_uart_rx;

    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 100000;
    localparam int BIT_CLKS = 16;
`ifdef SDU_RX_PARITY_EN
    localparam int LAT = 171;
`else
    localparam int LAT = 155;
`endif

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       rxd  = 1'b1;
    logic [7:0] dout;
    logic       dout_vld;
    logic       frame_err;
    logic       par_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int vld_cnt  = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int wide_cnt = 0;
    int excl_cnt = 0;
    int vld_cyc  = 0;
    int start_cyc = 0;
    logic [7:0] rx_hist[$];
    logic prev_vld  = 1'b0;
    logic prev_ferr = 1'b0;
    logic prev_perr = 1'b0;

    sdu_uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(16)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rxd      (rxd),
        .dout     (dout),
        .dout_vld (dout_vld),
        .frame_err(frame_err),
        .par_err  (par_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts pulses, records bytes, flags wide or
    // overlapping pulses. Sampled on the falling edge.
    always @(negedge clk) begin
        if (dout_vld) begin
            vld_cnt = vld_cnt + 1;
            vld_cyc = cyc;
            rx_hist.push_back(dout);
        end
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (par_err)   perr_cnt = perr_cnt + 1;
        if ((dout_vld && prev_vld) || (frame_err && prev_ferr) || (par_err && prev_perr))
            wide_cnt = wide_cnt + 1;
        if ((int'(dout_vld) + int'(frame_err) + int'(par_err)) > 1)
            excl_cnt = excl_cnt + 1;
        prev_vld  = dout_vld;
        prev_ferr = frame_err;
        prev_perr = par_err;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_bit);
        $display("[TB] sending 0x%02h stop=%0b par=%0b", data, stop_bit, par_bit);
        rxd = 1'b0;
        start_cyc = cyc;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            wait_clks(BIT_CLKS);
        end
`ifdef SDU_RX_PARITY_EN
        rxd = par_bit;
        wait_clks(BIT_CLKS);
`endif
        rxd = stop_bit;
        wait_clks(BIT_CLKS);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        rxd  = 1'b1;
        wait_clks(4);
        checks++; if (dout !== 8'h00) begin failures++; $display("[TB] FAIL reset_dout got=%h exp=00", dout); end
        checks++; if (dout_vld !== 1'b0) begin failures++; $display("[TB] FAIL reset_vld got=%b exp=0", dout_vld); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_ferr got=%b exp=0", frame_err); end
        checks++; if (par_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_perr got=%b exp=0", par_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        rstn = 1'b1;
        wait_clks(4);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        int base;
        base = vld_cnt;
        send_frame(8'h55, 1'b1, ^8'h55);
        wait_clks(4);
        checks++; if (vld_cnt !== base + 1) begin failures++; $display("[TB] FAIL single_count got=%0d exp=%0d", vld_cnt, base + 1); end
        checks++; if (dout !== 8'h55) begin failures++; $display("[TB] FAIL single_dout got=%h exp=55", dout); end
        checks++;
        if ((vld_cyc - start_cyc) < LAT - 1 || (vld_cyc - start_cyc) > LAT + 1) begin
            failures++;
            $display("[TB] FAIL single_latency got=%0d exp=%0d", vld_cyc - start_cyc, LAT);
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy got=%b exp=0", busy); end
        checks++; if (wide_cnt !== 0) begin failures++; $display("[TB] FAIL single_width got=%0d exp=0", wide_cnt); end
    endtask

    task automatic test_back_to_back();
        int base;
        int fbase;
        int n;
        logic [7:0] b0;
        logic [7:0] b1;
        base  = vld_cnt;
        fbase = ferr_cnt;
        n     = rx_hist.size();
        send_frame(8'hA3, 1'b1, ^8'hA3);
        send_frame(8'h0F, 1'b1, ^8'h0F);
        wait_clks(4);
        b0 = (rx_hist.size() > n)     ? rx_hist[n]     : 8'hxx;
        b1 = (rx_hist.size() > n + 1) ? rx_hist[n + 1] : 8'hxx;
        checks++; if (vld_cnt !== base + 2) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp=%0d", vld_cnt, base + 2); end
        checks++; if (b0 !== 8'hA3) begin failures++; $display("[TB] FAIL b2b_first got=%h exp=a3", b0); end
        checks++; if (b1 !== 8'h0F) begin failures++; $display("[TB] FAIL b2b_second got=%h exp=0f", b1); end
        checks++; if (ferr_cnt !== fbase) begin failures++; $display("[TB] FAIL b2b_ferr got=%0d exp=%0d", ferr_cnt, fbase); end
    endtask

    task automatic test_glitch();
        int base;
        base = vld_cnt;
        rxd = 1'b0;
        wait_clks(5);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL glitch_busy_hi got=%b exp=1", busy); end
        rxd = 1'b1;
        wait_clks(12);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL glitch_busy_lo got=%b exp=0", busy); end
        checks++; if (vld_cnt !== base) begin failures++; $display("[TB] FAIL glitch_count got=%0d exp=%0d", vld_cnt, base); end
        checks++; if (dout !== 8'h0F) begin failures++; $display("[TB] FAIL glitch_dout got=%h exp=0f", dout); end
        wait_clks(20);
    endtask

    task automatic test_break();
        int base;
        int fbase;
        base  = vld_cnt;
        fbase = ferr_cnt;
        send_frame(8'h3C, 1'b0, ^8'h3C);
        wait_clks(40);
        checks++; if (ferr_cnt !== fbase + 1) begin failures++; $display("[TB] FAIL break_ferr got=%0d exp=%0d", ferr_cnt, fbase + 1); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL break_busy got=%b exp=1", busy); end
        checks++; if (dout !== 8'h0F) begin failures++; $display("[TB] FAIL break_dout got=%h exp=0f", dout); end
        checks++; if (vld_cnt !== base) begin failures++; $display("[TB] FAIL break_count got=%0d exp=%0d", vld_cnt, base); end
        rxd = 1'b1;
        wait_clks(BIT_CLKS);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL break_exit got=%b exp=0", busy); end
        send_frame(8'h81, 1'b1, ^8'h81);
        wait_clks(4);
        checks++; if (dout !== 8'h81) begin failures++; $display("[TB] FAIL break_next_dout got=%h exp=81", dout); end
        checks++; if (vld_cnt !== base + 1) begin failures++; $display("[TB] FAIL break_next_count got=%0d exp=%0d", vld_cnt, base + 1); end
        checks++; if (ferr_cnt !== fbase + 1) begin failures++; $display("[TB] FAIL break_single_ferr got=%0d exp=%0d", ferr_cnt, fbase + 1); end
    endtask

    task automatic test_reset_mid();
        int base;
        int fbase;
        logic [7:0] v;
        base  = vld_cnt;
        fbase = ferr_cnt;
        v     = 8'h7E;
        rxd   = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            rxd = v[i];
            wait_clks(BIT_CLKS);
        end
        rxd = v[3];
        wait_clks(8);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_busy_hi got=%b exp=1", busy); end
        rstn = 1'b0;
        wait_clks(1);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy_lo got=%b exp=0", busy); end
        checks++; if (dout !== 8'h00) begin failures++; $display("[TB] FAIL rstmid_dout got=%h exp=00", dout); end
        rstn = 1'b1;
        rxd  = 1'b1;
        wait_clks(200);
        checks++; if (vld_cnt !== base) begin failures++; $display("[TB] FAIL rstmid_count got=%0d exp=%0d", vld_cnt, base); end
        checks++; if (ferr_cnt !== fbase) begin failures++; $display("[TB] FAIL rstmid_ferr got=%0d exp=%0d", ferr_cnt, fbase); end
        send_frame(8'h12, 1'b1, ^8'h12);
        wait_clks(4);
        checks++; if (dout !== 8'h12) begin failures++; $display("[TB] FAIL rstmid_next_dout got=%h exp=12", dout); end
        checks++; if (vld_cnt !== base + 1) begin failures++; $display("[TB] FAIL rstmid_next_count got=%0d exp=%0d", vld_cnt, base + 1); end
    endtask

`ifdef SDU_RX_PARITY_EN
    task automatic test_parity();
        int base;
        int pbase;
        base  = vld_cnt;
        pbase = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        wait_clks(4);
        checks++; if (perr_cnt !== pbase + 1) begin failures++; $display("[TB] FAIL parity_err got=%0d exp=%0d", perr_cnt, pbase + 1); end
        checks++; if (vld_cnt !== base) begin failures++; $display("[TB] FAIL parity_novld got=%0d exp=%0d", vld_cnt, base); end
        checks++; if (dout !== 8'h12) begin failures++; $display("[TB] FAIL parity_dout_kept got=%h exp=12", dout); end
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clks(4);
        checks++; if (dout !== 8'h07) begin failures++; $display("[TB] FAIL parity_ok_dout got=%h exp=07", dout); end
        checks++; if (vld_cnt !== base + 1) begin failures++; $display("[TB] FAIL parity_ok_count got=%0d exp=%0d", vld_cnt, base + 1); end
        checks++; if (perr_cnt !== pbase + 1) begin failures++; $display("[TB] FAIL parity_ok_err got=%0d exp=%0d", perr_cnt, pbase + 1); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_reset_mid();
`ifdef SDU_RX_PARITY_EN
        test_parity();
`endif
        wait_clks(4);
        checks++; if (wide_cnt !== 0) begin failures++; $display("[TB] FAIL pulse_width got=%0d exp=0", wide_cnt); end
        checks++; if (excl_cnt !== 0) begin failures++; $display("[TB] FAIL pulse_exclusive got=%0d exp=0", excl_cnt); end
`ifndef SDU_RX_PARITY_EN
        checks++; if (perr_cnt !== 0) begin failures++; $display("[TB] FAIL par_err_tied got=%0d exp=0", perr_cnt); end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
